sevenseg_mux_driver: RTL
========================

// Module: sevenseg_mux_driver
// PURPOSE
//   Parametrised time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   Cycles a one-hot anode select across the digits and decodes each 4-bit hex nibble to segments.
//   Inserts a blanking interval between digits to suppress ghosting.
//   Sits between the display-value registers and the board pins; generalises the 2-digit anode decoder.
// PARAMETERS
//   NUM_DIGITS   2      digits driven (>=1)
//   REFRESH_DIV  24000  clk cycles per digit slot (>BLANK_CYCLES); 2 kHz/digit at 48 MHz
//   BLANK_CYCLES 16     leading cycles of each slot with all anodes off (>=0)
// PORTS
//   clk        in   1             system clock
//   reset      in   1             synchronous, active-high reset
//   en         in   1             display enable
//   digits     in   4*NUM_DIGITS  hex values; digit k = digits[4k+3:4k], digit 0 least significant
//   seg        out  7             {g,f,e,d,c,b,a}, active-low
//   anode      out  NUM_DIGITS    anode[k] drives digit k, active-low
//   digit_idx  out  $clog2(max(NUM_DIGITS,2))  current slot index
//   frame_tick out  1             one-cycle pulse when the index wraps NUM_DIGITS-1 -> 0
// BEHAVIOUR
//   Reset (synchronous, priority over en): cnt=0, idx=0, anode=all 1, seg=7'h7F, frame_tick=0.
//     Reset mid-slot discards the slot; the first slot after reset starts with a full blank interval.
//   cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1: cnt->0, idx->idx+1 (wraps to 0 after NUM_DIGITS-1).
//   Phase FSM per slot: BLANK while cnt<BLANK_CYCLES, SHOW while cnt>=BLANK_CYCLES; BLANK->SHOW->BLANK.
//   Digit value latched into val at cnt==0 of each slot.
//     digits changes mid-slot do not appear until the next slot of that digit.
//   seg and anode are registered: one-cycle-delayed function of (phase, idx, val).
//     In BLANK: anode=all 1, seg=7'h7F.
//     In SHOW: anode[idx]=0 with all other anodes 1; seg=hex decode of val.
//   Hex decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//   frame_tick is registered and asserts for the single cycle after the idx wrap.
//     With NUM_DIGITS=1, frame_tick pulses every slot and idx stays 0.
//   digit_idx = idx (combinational from the register).
//   en=0: cnt and idx hold; next cycle anode=all 1 and seg=7'h7F.
//     On en 0->1: cnt reloads 0 and the same idx restarts with a full BLANK interval and a fresh latch.
//   No more than one anode is ever active in any cycle, including across the en and reset edges.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: a digit k>0 whose nibble and all more-significant nibbles are 0
//     is suppressed for its whole slot (anode all 1, seg=7'h7F). Digit 0 is always shown.
//     The test uses the latched values at slot start.
//   Macro undefined: every digit is displayed, including leading zeros.
// TESTING (NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2)
//   Reset held 3 cycles with en=1 -> anode=2'b11, seg=7'h7F, frame_tick=0, digit_idx=0 throughout.
//   Release reset, en=1, digits=8'h3A -> repeating pattern: 2 cycles anode=11, 6 cycles anode=10 (seg=7'h08),
//     2 cycles anode=11, 6 cycles anode=01 (seg=7'h30).
//     anode is never 2'b00; frame_tick pulses once per 16 cycles.
//   digits 8'h3A->8'h3B mid-SHOW of digit 0 -> seg stays 7'h08 for the rest of the slot.
//     The next digit-0 slot shows 7'h03.
//   en deasserted mid-SHOW of digit 1 for 5 cycles -> anode=11 and seg=7'h7F the next cycle.
//     On re-enable: 2 blank cycles, then 6 cycles of anode=01; digit_idx stays 1 while en=0.
//   Reset asserted mid-SHOW -> anode=11 and seg=7'h7F the next cycle.
//     After release: digit 0 slot with a full 2-cycle blank.
//   digits=8'h05: with LEADING_ZERO_BLANK_EN, the digit-1 slot keeps anode=11.
//     Without the macro, digit 1 shows anode=01, seg=7'h40. Digit 0 shows seg=7'h12 in both builds.

Source files
------------

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-slot blanking.
// Define LEADING_ZERO_BLANK_EN to suppress leading-zero digits above digit 0.
module sevenseg_mux_driver #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned REFRESH_DIV  = 24000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   en,
    input  logic [4*NUM_DIGITS-1:0]                                digits,
    output logic [6:0]                                             seg,
    output logic [NUM_DIGITS-1:0]                                  anode,
    output logic [$clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2)-1:0]   digit_idx,
    output logic                                                   frame_tick
);

    localparam int unsigned IdxW = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);
    localparam int unsigned CntW = $clog2((REFRESH_DIV > 1) ? REFRESH_DIV : 2);

    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankC  = CntW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {
        StBlank,
        StShow
    } phase_e;

    localparam phase_e PhaseInit = (BLANK_CYCLES > 0) ? StBlank : StShow;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [CntW-1:0]       cnt_q, cnt_d, cnt_cur;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [3:0]            val_q, val_d, val_cur, nib;
    phase_e                phase_q, phase_d, phase_cur;
    logic                  en_prev_q, en_prev_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  tick_q, tick_d;
    logic                  restart, slot_start, supp_cur;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  supp_q, supp_d, supp_new, all_zero;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        val_d     = val_q;
        phase_d   = phase_q;
        en_prev_d = en;
        seg_d     = 7'h7F;
        anode_d   = '1;
        tick_d    = 1'b0;

        // A 0->1 edge on en restarts the current digit's slot from its blank interval.
        restart    = en && !en_prev_q;
        cnt_cur    = restart ? '0 : cnt_q;
        phase_cur  = restart ? PhaseInit : phase_q;
        slot_start = (cnt_cur == '0);

        nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                nib = digits[4*k +: 4];
            end
        end
        val_cur = slot_start ? nib : val_q;

`ifdef LEADING_ZERO_BLANK_EN
        supp_d   = supp_q;
        all_zero = 1'b1;
        supp_new = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero && (digits[4*k +: 4] == 4'h0);
            if (idx_q == IdxW'(k)) begin
                supp_new = all_zero;
            end
        end
        supp_cur = slot_start ? supp_new : supp_q;
        if (en) begin
            supp_d = supp_cur;
        end
`else
        supp_cur = 1'b0;
`endif

        if (en) begin
            val_d = val_cur;
            if (phase_cur == StShow && !supp_cur) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (idx_q == IdxW'(k)) begin
                        anode_d[k] = 1'b0;
                    end
                end
                seg_d = hex_to_seg(val_cur);
            end

            if (cnt_cur == CntLast) begin
                cnt_d = '0;
                if (idx_q == IdxLast) begin
                    idx_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
            phase_d = (cnt_d < BlankC) ? StBlank : StShow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            val_q     <= 4'h0;
            phase_q   <= PhaseInit;
            en_prev_q <= 1'b0;
            seg_q     <= 7'h7F;
            anode_q   <= '1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            phase_q   <= phase_d;
            en_prev_q <= en_prev_d;
            seg_q     <= seg_d;
            anode_q   <= anode_d;
            tick_q    <= tick_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            supp_q <= 1'b0;
        end else begin
            supp_q <= supp_d;
        end
    end
`endif

    assign seg        = seg_q;
    assign anode      = anode_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule
